// File: rtl/shift_sequencer.sv
// Multi-cycle shift front-end: splits wide amounts into passes of at most STEP_MAX bits.
// Define SHIFT_SAT_EN to clamp the effective amount and shorten worst-case latency.
module general_shifter (
  input  logic [7:0] i,
  input  logic [3:0] n,
  input  logic       ar,
  input  logic       lr,
  input  logic       rot,
  output logic [7:0] o
);
  logic [15:0] dbl_l;
  logic [15:0] dbl_r;

  assign dbl_l = {i, i} << n;
  assign dbl_r = {i, i} >> n;

  always_comb begin
    o = i;
    unique case (1'b1)
      rot && lr:          o = dbl_l[15:8];
      rot && !lr:         o = dbl_r[7:0];
      !rot && lr:         o = i << n;
      !rot && !lr && ar:  o = $signed(i) >>> n;
      default:            o = i >> n;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int AMT_W    = 8,
  parameter int STEP_MAX = 7
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;
  localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

  state_t           state;
  state_t           state_nx;
  logic [7:0]       data;
  logic [1:0]       op;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_nx;
  logic [AMT_W-1:0] eff_amt;
  logic [2:0]       step;
  logic [7:0]       core_o;
  logic             accept;
  logic             ar;
  logic             lr;
  logic             rot;

`ifdef SHIFT_SAT_EN
  // Results saturate past 8 bits, so passes beyond that are wasted.
  always_comb begin
    eff_amt = in_amt;
    if (in_op == OP_ROL)
      eff_amt = {{(AMT_W-3){1'b0}}, in_amt[2:0]};
    else if (in_amt > AMT_W'(8))
      eff_amt = AMT_W'(8);
  end
`else
  assign eff_amt = in_amt;
`endif

  assign step   = (rem < STEP_LIM) ? rem[2:0] : STEP_LIM[2:0];
  assign rem_nx = rem - AMT_W'(step);
  assign accept = in_valid && in_ready;

  assign lr  = (op == OP_SLL) || (op == OP_ROL);
  assign ar  = (op == OP_SRA);
  assign rot = (op == OP_ROL);

  general_shifter u_core (
    .i   (data),
    .n   ({1'b0, step}),
    .ar  (ar),
    .lr  (lr),
    .rot (rot),
    .o   (core_o)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = (eff_amt != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (rem_nx == '0) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // out_data only moves on entry to DONE so it stays stable afterwards.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data     <= '0;
      op       <= '0;
      rem      <= '0;
      out_data <= '0;
    end else if (accept) begin
      data <= in_data;
      op   <= in_op;
      rem  <= eff_amt;
      if (eff_amt == '0) out_data <= in_data;
    end else if (state == RUN) begin
      data <= core_o;
      rem  <= rem_nx;
      if (rem_nx == '0) out_data <= core_o;
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a result/latency scoreboard.
// Honours SHIFT_SAT_EN for expected latency only.
module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [7:0] in_amt = '0;
  logic [1:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t sb[$];

  shift_sequencer dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] d,
                                       input int a,
                                       input logic [1:0] op);
    logic [7:0] r;
    r = d;
    for (int k = 0; k < a; k++) begin
      case (op)
        2'b00:   r = {r[6:0], 1'b0};
        2'b01:   r = {1'b0, r[7:1]};
        2'b10:   r = {r[7], r[7:1]};
        default: r = {r[6:0], r[7]};
      endcase
    end
    return r;
  endfunction

  function automatic int passes(input int a, input logic [1:0] op);
    int e;
    e = a;
`ifdef SHIFT_SAT_EN
    if (op == 2'b11) e = a % 8;
    else if (a > 8)  e = 8;
`endif
    return (e + 6) / 7;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] d, input int a,
                       input logic [1:0] op);
    exp_t e;
    in_data  = d;
    in_amt   = 8'(a);
    in_op    = op;
    in_valid = 1'b1;
    chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.data = model(d, a, op);
    e.lat  = passes(a, op) + 1;
    sb.push_back(e);
  endtask

  task automatic wait_out(input string tag);
    int   cyc;
    exp_t e;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
      chk({tag, "_data"}, 32'(out_data), 32'(e.data));
    end
  endtask

  task automatic handshake(input string tag, input logic [7:0] held);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_held"}, 32'(out_data), 32'(held));
  endtask

  initial begin
    int nv;
    logic [7:0] d;
    logic [1:0] op;
    int a;

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;

    issue(8'h81, 1, 2'b00);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_out("t1");
    handshake("t1", 8'h02);

    issue(8'h80, 20, 2'b10);
    wait_out("t2");
    handshake("t2", 8'hFF);

    issue(8'h81, 9, 2'b11);
    wait_out("t3");
    handshake("t3", 8'h03);

    issue(8'hA5, 0, 2'b01);
    wait_out("t4");
    handshake("t4", 8'hA5);

    out_ready = 1'b0;
    issue(8'h0F, 4, 2'b00);
    wait_out("t5");
    in_data  = 8'hF0;
    in_amt   = 8'd3;
    in_op    = 2'b01;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_stall_valid", 32'(out_valid), 32'd1);
      chk("t5_stall_data", 32'(out_data), 32'hF0);
      chk("t5_stall_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("t5_hs_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("t5_after_hs_valid", 32'(out_valid), 32'd0);
    chk("t5_after_hs_busy", 32'(busy), 32'd0);
    issue(8'hF0, 3, 2'b01);
    wait_out("t5b");
    handshake("t5b", 8'h1E);

    issue(8'hFF, 200, 2'b01);
    chk("t6_running", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) nv++;
    end
    chk("t6_no_output", 32'(nv), 32'd0);
    issue(8'h3C, 2, 2'b00);
    wait_out("t6b");
    handshake("t6b", 8'hF0);

    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom);
      a  = int'($urandom_range(0, 255));
      op = 2'($urandom);
      issue(d, a, op);
      wait_out("rnd");
      handshake("rnd", model(d, a, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
